mem_bus_responder: RTL and testbench

- Simulation-side responder for the core's instruction/data bus protocol: req/gnt address phase, then in-order rvalid response phase.
- Sits behind a bus device port, or directly on a core host port, in DV tops.
- Backs a word-addressed memory with configurable grant delay, fixed response latency and a bounded number of outstanding transactions.
- Exercises the initiator's stall, pipelining and error paths, which a zero-wait RAM cannot reach.

---
 rtl/mem_bus_responder_if.sv | 15 +
 rtl/mem_bus_responder.sv | 123 ++++++++++++
 tb/tb_mem_bus_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - req/gnt address phase plus rvalid response phase bus bundle
interface mem_bus_responder_if;
   logic        req;
   logic        gnt;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - word memory responder with grant delay, fixed latency, outstanding limit
// Optional MEM_BUS_RESPONDER_ERR_INJECT_EN adds err_inject_i to force an error response.
module mem_bus_responder #(
   parameter int          Depth          = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0,
   parameter int          GntDelay       = 0,
   parameter int          RespLatency    = 1,
   parameter int          MaxOutstanding = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
`ifdef MEM_BUS_RESPONDER_ERR_INJECT_EN
   input  logic               err_inject_i,
`endif
   mem_bus_responder_if.slave bus
);
   localparam int          AW       = $clog2(Depth);
   localparam int          CW       = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
   localparam int          OW       = $clog2(MaxOutstanding + 1);
   localparam logic [32:0] WinBytes = 33'(Depth) * 33'd4;

   typedef enum logic {IDLE, WAIT} state_e;

   state_e                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [OW-1:0]          outst_q, outst_d;
   logic [RespLatency-1:0] vld_q;
   logic [RespLatency-1:0] err_q;
   logic [31:0]            dat_q [RespLatency];

   logic [31:0]            mem [Depth];
   logic [31:0]            offset;
   logic [AW-1:0]          idx;
   logic                   in_range, inject, entry_err, delay_met, grantable, retire, gnt;
   logic [31:0]            entry_dat;

   // Subtracting the base first makes addresses below the window wrap to huge offsets.
   assign offset   = bus.addr - BaseAddr;
   assign idx      = offset[AW+1:2];
   assign in_range = {1'b0, offset} < WinBytes;

`ifdef MEM_BUS_RESPONDER_ERR_INJECT_EN
   assign inject = err_inject_i;
`else
   assign inject = 1'b0;
`endif

   assign entry_err = !in_range || inject;
   assign entry_dat = (bus.we || entry_err) ? 32'h0 : mem[idx];
   assign retire    = vld_q[RespLatency-1];
   assign delay_met = (GntDelay == 0) || ((state_q == WAIT) && (cnt_q == CW'(GntDelay)));
   assign grantable = (outst_q < OW'(MaxOutstanding)) || retire;
   assign gnt       = rst_ni && bus.req && delay_met && grantable;

   assign bus.gnt    = gnt;
   assign bus.rvalid = retire;
   assign bus.rdata  = dat_q[RespLatency-1];
   assign bus.err    = err_q[RespLatency-1];

   always_comb begin
      outst_d = outst_q;
      if (gnt && !retire) begin
         outst_d = outst_q + OW'(1);
      end else if (!gnt && retire) begin
         outst_d = outst_q - OW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         outst_q <= '0;
         vld_q   <= '0;
         err_q   <= '0;
         for (int i = 0; i < RespLatency; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         outst_q  <= outst_d;
         // Empty slots carry zero data/err so the outputs are clean whenever rvalid is low.
         vld_q[0] <= gnt;
         err_q[0] <= gnt && entry_err;
         dat_q[0] <= gnt ? entry_dat : 32'h0;
         for (int i = 1; i < RespLatency; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
         case (state_q)
            IDLE: begin
               if (bus.req && (GntDelay != 0)) begin
                  state_q <= WAIT;
                  cnt_q   <= CW'(1);
               end
            end
            WAIT: begin
               if (!bus.req || gnt) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q != CW'(GntDelay)) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Contents survive reset so data written before a reset can be read back after it.
   always_ff @(posedge clk_i) begin
      if (gnt && bus.we && !entry_err) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.be[k]) begin
               mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - two responder configurations driven in lockstep against a transaction-level model
module tb_mem_bus_responder;
   localparam int          A_DEPTH = 1024;
   localparam logic [31:0] A_BASE  = 32'h0;
   localparam int          A_GD    = 0;
   localparam int          A_LAT   = 1;
   localparam int          A_MAXO  = 2;
   localparam int          B_DEPTH = 16;
   localparam logic [31:0] B_BASE  = 32'h40;
   localparam int          B_GD    = 3;
   localparam int          B_LAT   = 4;
   localparam int          B_MAXO  = 2;

   logic        clk;
   logic        rst_n;
   logic        req, we, inj;
   logic [3:0]  be;
   logic [31:0] addr, wdata;

   logic        gnt_w [2];
   logic        rv_w  [2];
   logic [31:0] rd_w  [2];
   logic        er_w  [2];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int          inst;
      int          due;
      logic        err;
      logic [31:0] data;
   } resp_t;

   resp_t       rq [$];
   logic [31:0] mm [2][1024];
   int          held [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bus_responder_if bus ();
      assign bus.req   = req;
      assign bus.we    = we;
      assign bus.be    = be;
      assign bus.addr  = addr;
      assign bus.wdata = wdata;
      assign gnt_w[g]  = bus.gnt;
      assign rv_w[g]   = bus.rvalid;
      assign rd_w[g]   = bus.rdata;
      assign er_w[g]   = bus.err;

      mem_bus_responder #(
         .Depth          (g == 0 ? A_DEPTH : B_DEPTH),
         .BaseAddr       (g == 0 ? A_BASE  : B_BASE),
         .GntDelay       (g == 0 ? A_GD    : B_GD),
         .RespLatency    (g == 0 ? A_LAT   : B_LAT),
         .MaxOutstanding (g == 0 ? A_MAXO  : B_MAXO)
      ) u_dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
`ifdef MEM_BUS_RESPONDER_ERR_INJECT_EN
         .err_inject_i (inj),
`endif
         .bus          (bus)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of stimulus, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic int cfg_depth(int i); return (i == 0) ? A_DEPTH : B_DEPTH; endfunction
   function automatic logic [31:0] cfg_base(int i); return (i == 0) ? A_BASE : B_BASE; endfunction
   function automatic int cfg_gd(int i); return (i == 0) ? A_GD : B_GD; endfunction
   function automatic int cfg_lat(int i); return (i == 0) ? A_LAT : B_LAT; endfunction
   function automatic int cfg_maxo(int i); return (i == 0) ? A_MAXO : B_MAXO; endfunction

   task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s inst%0d cycle %0d: observed %h expected %h", tag, i, cyc, got, exp);
      end
   endtask

   // Transaction-level view: a request is accepted once it has been held GntDelay cycles
   // and fewer than MaxOutstanding responses are pending; its response is due LAT cycles later.
   task automatic model_cycle(int i);
      int          f;
      int          outs;
      logic        due, ready, exp_gnt, e;
      logic [31:0] exp_rd, off, d;
      logic        exp_err;
      int          w;
      f = -1;
      outs = 0;
      foreach (rq[k]) begin
         if (rq[k].inst == i) begin
            if (f < 0) f = k;
            outs++;
         end
      end
      if (!rst_n) begin
         chk("rst_gnt", i, 32'(gnt_w[i]), 32'h0);
         chk("rst_rvalid", i, 32'(rv_w[i]), 32'h0);
         chk("rst_rdata", i, rd_w[i], 32'h0);
         chk("rst_err", i, 32'(er_w[i]), 32'h0);
         for (int k = rq.size() - 1; k >= 0; k--) begin
            if (rq[k].inst == i) rq.delete(k);
         end
         held[i] = 0;
      end else begin
         due     = (f >= 0) && (rq[f].due == cyc);
         exp_rd  = due ? rq[f].data : 32'h0;
         exp_err = due ? rq[f].err : 1'b0;
         ready   = (cfg_gd(i) == 0) || (held[i] >= cfg_gd(i));
         exp_gnt = req && ready && ((outs < cfg_maxo(i)) || due);
         chk("gnt", i, 32'(gnt_w[i]), 32'(exp_gnt));
         chk("rvalid", i, 32'(rv_w[i]), 32'(due));
         chk("rdata", i, rd_w[i], exp_rd);
         chk("err", i, 32'(er_w[i]), 32'(exp_err));
         if (due) rq.delete(f);
         if (exp_gnt) begin
            off = addr - cfg_base(i);
            e   = !(longint'(off) < longint'(cfg_depth(i)) * 4) || inj;
            w   = int'(off >> 2);
            d   = (we || e) ? 32'h0 : mm[i][w];
            if (we && !e) begin
               for (int k = 0; k < 4; k++) begin
                  if (be[k]) mm[i][w][8*k +: 8] = wdata[8*k +: 8];
               end
            end
            rq.push_back('{inst: i, due: cyc + cfg_lat(i), err: e, data: d});
            held[i] = 0;
         end else begin
            held[i] = req ? held[i] + 1 : 0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_cycle(i);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input int hold, input int gap);
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      repeat (hold) step();
      req = 1'b0;
      repeat (gap) step();
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; inj = 1'b0;
      held[0] = 0;
      held[1] = 0;
      step();
      step();
      rst_n = 1'b1;
      step();

      for (int w = 0; w < 32; w++) txn(1'b1, 4'hF, 32'(w * 4), $urandom, 5, 1);

      txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 5, 1);
      txn(1'b0, 4'hF, 32'h10, 32'h0, 5, 1);
      txn(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 5, 1);
      txn(1'b1, 4'h5, 32'h20, 32'h11223344, 5, 1);
      txn(1'b0, 4'h0, 32'h20, 32'h0, 5, 1);
      txn(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 5, 1);
      txn(1'b0, 4'hF, 32'h1000, 32'h0, 5, 1);
      txn(1'b0, 4'hF, 32'h0, 32'h0, 5, 1);
      txn(1'b0, 4'hF, 32'h44, 32'h0, 12, 6);

      // Reset while reads are in flight on both instances.
      req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h48;
      repeat (4) step();
      rst_n = 1'b0;
      req = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) chk("rst_async_rvalid", i, 32'(rv_w[i]), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      repeat (6) step();
      txn(1'b0, 4'hF, 32'h10, 32'h0, 5, 1);
      txn(1'b0, 4'hF, 32'h48, 32'h0, 5, 1);

      repeat (300) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = 32'h1000;
         else if (r == 1) a = 32'hFFFFFFFC;
         else a = 32'($urandom_range(0, 31) * 4) | 32'($urandom_range(0, 3));
`ifdef MEM_BUS_RESPONDER_ERR_INJECT_EN
         inj = ($urandom_range(0, 7) == 0);
`endif
         txn(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom,
             $urandom_range(1, 6), $urandom_range(0, 1));
      end
      inj = 1'b0;
      req = 1'b0;
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
